// File: rtl/muldiv_unit.sv
// muldiv_unit: sequential 16-bit unsigned multiply/divide unit.
//   MUL/MULH: radix-2 shift-add, one multiplier bit per RUN cycle.
//   DIV/REM : restoring division, one quotient bit per RUN cycle.
//             Present only when MULDIV_DIV_EN is defined. Otherwise DIV/REM
//             finish immediately with err=1 and result=0.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           begin an operation (sampled in IDLE only)
//   op              00 MUL, 01 MULH, 10 DIV, 11 REM
//   opa, opb        operands (captured on the accepting edge)
//   dest            destination register index (captured)
//   busy            operation in flight, including the completion cycle
//   done            one-cycle completion pulse
//   err             divide-by-zero or unsupported op, valid with done
//   result, wreg    register-file write data and index, held between ops
//   write_en        register-file write strobe (done and not err)
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [15:0] opa,
  input  logic [15:0] opb,
  input  logic [2:0]  dest,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] result,
  output logic [2:0]  wreg,
  output logic        write_en
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [1:0]  op_q;
  logic [2:0]  dest_q;
  logic [31:0] acc;  // product accumulator
  logic [31:0] mc;   // multiplicand, shifted left each step
  logic [15:0] mp;   // multiplier (MUL) or dividend/quotient shift register (DIV)

`ifdef MULDIV_DIV_EN
  logic [15:0] b_q;
  logic [15:0] rem;
  logic [16:0] trial;
  logic        div_zero;

  always_comb begin
    trial    = {rem, mp[15]};
    div_zero = (b_q == 16'h0000);
  end
`endif

  // Outputs are registered from the DONE state, so the done/write_en pulse
  // lands in the cycle after DONE; busy is held through that pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      mc       <= '0;
      mp       <= '0;
      op_q     <= '0;
      dest_q   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      write_en <= 1'b0;
      result   <= '0;
      wreg     <= '0;
`ifdef MULDIV_DIV_EN
      b_q      <= '0;
      rem      <= '0;
`endif
    end else begin
      done     <= 1'b0;
      err      <= 1'b0;
      write_en <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q   <= op;
            dest_q <= dest;
            cnt    <= '0;
            acc    <= '0;
            mc     <= {16'h0000, opa};
            busy   <= 1'b1;
`ifdef MULDIV_DIV_EN
            mp     <= op[1] ? opa : opb;
            b_q    <= opb;
            rem    <= '0;
            state  <= RUN;
`else
            mp     <= opb;
            state  <= op[1] ? DONE : RUN;
`endif
          end else if (done) begin
            busy <= 1'b0;
          end
        end
        RUN: begin
`ifdef MULDIV_DIV_EN
          if (op_q[1]) begin
            if (trial >= {1'b0, b_q}) begin
              rem <= trial[15:0] - b_q;
              mp  <= {mp[14:0], 1'b1};
            end else begin
              rem <= trial[15:0];
              mp  <= {mp[14:0], 1'b0};
            end
          end else begin
            if (mp[0]) acc <= acc + mc;
            mc <= {mc[30:0], 1'b0};
            mp <= {1'b0, mp[15:1]};
          end
`else
          if (mp[0]) acc <= acc + mc;
          mc <= {mc[30:0], 1'b0};
          mp <= {1'b0, mp[15:1]};
`endif
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) state <= DONE;
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b1;
          wreg  <= dest_q;
`ifdef MULDIV_DIV_EN
          case (op_q)
            2'b00:   result <= acc[15:0];
            2'b01:   result <= acc[31:16];
            2'b10:   result <= mp;
            default: result <= rem;
          endcase
          err      <= op_q[1] && div_zero;
          write_en <= !(op_q[1] && div_zero);
`else
          if (op_q[1]) begin
            result   <= '0;
            err      <= 1'b1;
            write_en <= 1'b0;
          end else begin
            result   <= op_q[0] ? acc[31:16] : acc[15:0];
            write_en <= 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit against an
// arithmetic reference model. Follows MULDIV_DIV_EN like the design.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [1:0]  op;
  logic [15:0] opa, opb;
  logic [2:0]  dest;
  logic        busy, done, err, write_en;
  logic [15:0] result;
  logic [2:0]  wreg;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
    .dest(dest), .busy(busy), .done(done), .err(err), .result(result),
    .wreg(wreg), .write_en(write_en)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_result(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    p = 32'(a) * 32'(b);
    if (o[1] && !DIV_EN) return 16'h0000;
    case (o)
      2'b00:   return p[15:0];
      2'b01:   return p[31:16];
      2'b10:   return (b == 0) ? 16'hFFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic model_err(input logic [1:0] o, input logic [15:0] b);
    return o[1] && (!DIV_EN || b == 0);
  endfunction

  // Issues one operation; dup_at>0 drives an extra start (MUL 2x2) just before that edge.
  task automatic run_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] d, input int unsigned dup_at);
    int unsigned lat, done_edge, wen_edge, done_cnt, wen_cnt;
    logic [15:0] res_seen;
    logic        err_seen, wen_seen, busy_ok;
    logic [2:0]  wreg_seen;
    lat = (o[1] && !DIV_EN) ? 1 : 17;
    done_edge = 0; wen_edge = 0; done_cnt = 0; wen_cnt = 0; busy_ok = 1'b1;
    res_seen = '0; err_seen = 1'b0; wen_seen = 1'b0; wreg_seen = '0;
    @(negedge clk);
    start = 1'b1; op = o; opa = a; opb = b; dest = d;
    @(posedge clk); #1;
    start = 1'b0; op = 2'($urandom); opa = 16'($urandom); opb = 16'($urandom); dest = 3'($urandom);
    check("busy_after_accept", busy, 1);
    for (int unsigned k = 1; k <= lat + 1; k++) begin
      if (k == dup_at) begin
        @(negedge clk);
        start = 1'b1; op = 2'b00; opa = 16'd2; opb = 16'd2; dest = 3'd7;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        done_cnt++;
        if (done_edge == 0) begin
          done_edge = k; res_seen = result; err_seen = err; wen_seen = write_en; wreg_seen = wreg;
        end
      end
      if (write_en) begin
        wen_cnt++;
        if (wen_edge == 0) wen_edge = k;
      end
      if (k <= lat && busy !== 1'b1) busy_ok = 1'b0;
    end
    check("done_latency", done_edge, lat);
    check("done_pulses", done_cnt, 1);
    check("result", res_seen, model_result(o, a, b));
    check("err", err_seen, model_err(o, b));
    check("write_en", wen_seen, !model_err(o, b));
    check("wen_pulses", wen_cnt, model_err(o, b) ? 0 : 1);
    if (!model_err(o, b)) check("wen_latency", wen_edge, lat);
    check("wreg", wreg_seen, d);
    check("busy_held", busy_ok, 1);
    check("busy_released", busy, 0);
    check("result_held", result, model_result(o, a, b));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = '0; opa = '0; opb = '0; dest = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_wen", write_en, 0);
    check("rst_result", result, 0);
    check("rst_wreg", wreg, 0);
    @(negedge clk); rst = 1'b0;

    run_op(2'b00, 16'd3, 16'd5, 3'd1, 0);
    run_op(2'b00, 16'hFFFF, 16'hFFFF, 3'd2, 0);
    run_op(2'b01, 16'hFFFF, 16'hFFFF, 3'd3, 0);
    run_op(2'b10, 16'd100, 16'd7, 3'd4, 0);
    run_op(2'b11, 16'd100, 16'd7, 3'd5, 0);
    run_op(2'b10, 16'h1234, 16'h0000, 3'd6, 0);
    run_op(2'b11, 16'h1234, 16'h0000, 3'd7, 0);

    // second start while running is ignored
    run_op(2'b00, 16'd3, 16'd5, 3'd1, 5);

    // reset mid-run aborts without a write
    @(negedge clk);
    start = 1'b1; op = 2'b00; opa = 16'd9; opb = 16'd9; dest = 3'd2;
    @(posedge clk); #1; start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", busy, 0);
    check("abort_result", result, 0);
    @(negedge clk); rst = 1'b0;
    begin
      int unsigned pulses = 0;
      for (int i = 0; i < 20; i++) begin
        @(posedge clk); #1;
        if (done || write_en || busy) pulses++;
      end
      check("abort_quiet", pulses, 0);
    end
    run_op(2'b00, 16'd4, 16'd4, 3'd3, 0);

    // reset wins over start on the same edge
    @(negedge clk); rst = 1'b1; start = 1'b1; op = 2'b00; opa = 16'd1; opb = 16'd1;
    @(posedge clk); #1;
    check("rst_over_start", busy, 0);
    @(negedge clk); rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    check("rst_over_start_idle", busy, 0);

    // randomized operations
    for (int i = 0; i < 16; i++) begin
      logic [1:0]  ro;
      logic [15:0] ra, rb;
      ro = 2'($urandom);
      ra = 16'($urandom);
      rb = ($urandom_range(3, 0) == 0) ? 16'h0000 : 16'($urandom);
      run_op(ro, ra, rb, 3'($urandom), (i % 4 == 1) ? $urandom_range(10, 2) : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have the port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port `rst`, input, 1 bit: reset, synchronous, active-high.
REQ-003 The block SHALL have the port `start`, input, 1 bit: request to begin an operation; sampled only in IDLE.
REQ-004 The block SHALL have the port `op`, input, 2 bits: operation select; 00 MUL (low 16 of product), 01 MULH (high 16 of product), 10 DIV (quotient), 11 REM (remainder); all unsigned.
REQ-005 The block SHALL have the ports `opa` and `opb`, input, 16 bits each: operands, driven from the register file read1/read2 ports.
REQ-006 The block SHALL have the port `dest`, input, 3 bits: destination register index.
REQ-007 The block SHALL have the port `busy`, output, 1 bit: high in RUN and DONE.
REQ-008 The block SHALL have the port `done`, output, 1 bit: one-cycle completion pulse.
REQ-009 The block SHALL have the port `err`, output, 1 bit: high with `done` on divide-by-zero or unsupported op.
REQ-010 The block SHALL have the port `result`, output, 16 bits: result; feeds register file writedata.
REQ-011 The block SHALL have the port `wreg`, output, 3 bits: captured `dest`; feeds register file wreg.
REQ-012 The block SHALL have the port `write_en`, output, 1 bit: register file write strobe.

Function
REQ-013 The block SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-014 IDLE->RUN SHALL occur on the edge where `start`=1; on that edge the block SHALL capture `op`, `opa`, `opb` and `dest`, and clear the 4-bit iteration counter and the 32-bit accumulator.
REQ-015 `start` SHALL be ignored in RUN and DONE; operand changes after capture SHALL have no effect.
REQ-016 MUL/MULH SHALL use radix-2 shift-add: one multiplier bit per RUN cycle, LSB first, 32-bit product.
REQ-017 DIV/REM SHALL use restoring division: one quotient bit per RUN cycle, MSB first, 16-bit remainder register.
REQ-018 RUN SHALL last exactly 16 cycles (counter 0..15); RUN->DONE SHALL occur when counter=15.
REQ-019 DONE SHALL last exactly 1 cycle; DONE->IDLE SHALL be unconditional.
REQ-020 Latency: `done` SHALL be high in the cycle following the 17th edge after the accepting edge; a new `start` SHALL be accepted no earlier than the 18th edge.
REQ-021 In DONE, `done`=1 and `result`/`wreg` SHALL be valid.
REQ-022 In DONE, `write_en`=1 unless `err`=1, in which case `write_en`=0.
REQ-023 Outside DONE, `done`, `write_en` and `err` SHALL be 0; `result` and `wreg` SHALL hold their last values.
REQ-024 Divide by zero (`opb`=0, DIV/REM) SHALL complete with full latency and give quotient 16'hFFFF, remainder=`opa`, `err`=1, `write_en`=0.
REQ-025 Overflow is impossible; MUL SHALL discard the upper 16 bits and MULH the lower 16 bits.

Reset
REQ-026 `rst`=1 at an edge SHALL force IDLE from any state, including mid-RUN, aborting the operation with no `write_en` pulse.
REQ-027 Reset values SHALL be: `busy`=0, `done`=0, `err`=0, `write_en`=0, `result`=16'h0000, `wreg`=3'b000, counter=0, accumulator=0.
REQ-028 `rst` SHALL take priority over `start` on the same edge.

Configuration
REQ-029 The macro MULDIV_DIV_EN SHALL control divider support.
REQ-030 With MULDIV_DIV_EN defined, DIV/REM SHALL behave per REQ-017 and REQ-024.
REQ-031 Without MULDIV_DIV_EN, no divider logic SHALL be present; DIV/REM SHALL go IDLE->DONE directly (`done` one cycle after the accepting edge) with `result`=16'h0000, `err`=1, `write_en`=0.
REQ-032 MUL/MULH behaviour SHALL be identical with and without MULDIV_DIV_EN.

Verification
REQ-033 The bench SHALL cover MUL with `opa`=3, `opb`=5, `dest`=1 -> `result`=16'h000F, `wreg`=1, `write_en` pulse exactly 17 edges after acceptance.
REQ-034 The bench SHALL cover `opa`=`opb`=16'hFFFF -> MUL gives 16'h0001; MULH gives 16'hFFFE.
REQ-035 The bench SHALL cover `opa`=100, `opb`=7 (MULDIV_DIV_EN defined) -> DIV gives 14, REM gives 2, `err`=0.
REQ-036 The bench SHALL cover DIV with `opb`=0, `opa`=16'h1234 -> `result`=16'hFFFF, `err`=1, `write_en`=0; REM gives `result`=16'h1234.
REQ-037 The bench SHALL cover MUL 3x5 followed by a second `start` (MUL 2x2) at RUN cycle 5 -> second request ignored, `result`=15, `busy` stays 1 until DONE ends.
REQ-038 The bench SHALL cover `rst` asserted at RUN cycle 8 -> next cycle `busy`=0, `result`=0, no `write_en` pulse; a subsequent MUL 4x4 gives 16.
